// File: rtl/multi_phase_integrator_pkg.sv
// phase_pkg: shared types and constants for the multi-phase integrator.
//   phase_t   fine phase / frequency word (INT_BITS+FRAC_BITS) for the default build
//   ch_t      channel index for the default build
//   state_e   sweep sequencer state
//   mod_const wrap modulus in fine units: PERIOD << FRAC_BITS
package phase_pkg;
  localparam int CHANNELS_DEF  = 8;
  localparam int PERIOD_DEF    = 48000;
  localparam int FRAC_BITS_DEF = 8;
  localparam int INT_BITS_DEF  = 16;

  typedef logic [INT_BITS_DEF+FRAC_BITS_DEF-1:0] phase_t;
  typedef logic [$clog2(CHANNELS_DEF)-1:0]       ch_t;

  typedef enum logic {
    ST_IDLE = 1'b0,
    ST_RUN  = 1'b1
  } state_e;

  function automatic logic [63:0] mod_const(input int unsigned period,
                                            input int unsigned frac_bits);
    return 64'(period) << frac_bits;
  endfunction
endpackage

// File: rtl/multi_phase_integrator_mod_add.sv
// phase_mod_add: combinational (a + b) mod MOD with a wrap flag.
//   a    in  PW      unsigned phase, assumed in [0, MOD)
//   b    in  PW+1    signed addend, assumed |b| < MOD so one correction suffices
//   sum  out PW      result in [0, MOD)
//   wrap out 1       a correction (either direction) was applied
module phase_mod_add #(
  parameter int          PW  = 24,
  parameter logic [PW:0] MOD = '0
) (
  input  logic              [PW-1:0] a,
  input  logic signed       [PW:0]   b,
  output logic              [PW-1:0] sum,
  output logic                       wrap
);
  localparam logic signed [PW+1:0] MODS = $signed({1'b0, MOD});

  logic signed [PW+1:0] s;

  always_comb begin
    s    = $signed({2'b00, a}) + $signed({b[PW], b});
    wrap = 1'b0;
    if (s[PW+1]) begin
      s    = s + MODS;
      wrap = 1'b1;
    end else if (s >= MODS) begin
      s    = s - MODS;
      wrap = 1'b1;
    end
    sum = s[PW-1:0];
  end
endmodule

// File: rtl/multi_phase_integrator.sv
// multi_phase_integrator: time-multiplexed N-channel phase accumulator.
// Each tick starts a sweep that updates one channel per cycle:
//   phase := (phase + freq) mod (PERIOD << FRAC_BITS)
// Ports:
//   clk, rst             clock, synchronous active-high reset
//   tick                 start a sweep (ignored while busy -> overrun pulse)
//   freq_we/ch/data      frequency write, clamped to MOD-1
//   sync_req/ch/phase    force a channel phase (reduced by one MOD if needed)
//   busy, overrun        sweep in progress, dropped-tick pulse
//   out_valid/ch/phase/wrap  registered per-channel result, held between strobes
// Optional: MULTI_PHASE_INTEGRATOR_PM_EN adds pm_in (phase modulation applied
// to the reported phase only) and proc_ch (channel processed this cycle).
module multi_phase_integrator
  import phase_pkg::*;
#(
  parameter int CHANNELS  = CHANNELS_DEF,
  parameter int PERIOD    = PERIOD_DEF,
  parameter int FRAC_BITS = FRAC_BITS_DEF,
  parameter int INT_BITS  = INT_BITS_DEF
) (
  input  logic                              clk,
  input  logic                              rst,
  input  logic                              tick,
  input  logic                              freq_we,
  input  logic [$clog2(CHANNELS)-1:0]       freq_ch,
  input  logic [INT_BITS+FRAC_BITS-1:0]     freq_data,
  input  logic                              sync_req,
  input  logic [$clog2(CHANNELS)-1:0]       sync_ch,
  input  logic [INT_BITS+FRAC_BITS-1:0]     sync_phase,
`ifdef MULTI_PHASE_INTEGRATOR_PM_EN
  input  logic signed [INT_BITS+FRAC_BITS-1:0] pm_in,
  output logic [$clog2(CHANNELS)-1:0]       proc_ch,
`endif
  output logic                              busy,
  output logic                              overrun,
  output logic                              out_valid,
  output logic [$clog2(CHANNELS)-1:0]       out_ch,
  output logic [INT_BITS-1:0]               out_phase,
  output logic                              out_wrap
);
  localparam int          CW       = $clog2(CHANNELS);
  localparam int          PW       = INT_BITS + FRAC_BITS;
  localparam logic [PW:0] MOD      = (PW+1)'(mod_const(PERIOD, FRAC_BITS));
  localparam logic [PW-1:0] FREQ_MAX = PW'(MOD - 1'b1);
  localparam logic [CW-1:0] LAST_CH  = CW'(CHANNELS - 1);

  state_e          state_q, state_d;
  logic [CW-1:0]   ch_q, ch_d;
  logic [PW-1:0]   phase_q [CHANNELS];
  logic [PW-1:0]   phase_d [CHANNELS];
  logic [PW-1:0]   freq_q  [CHANNELS];
  logic [PW-1:0]   freq_d  [CHANNELS];
  logic            out_valid_q, out_valid_d;
  logic [CW-1:0]   out_ch_q, out_ch_d;
  logic [INT_BITS-1:0] out_phase_q, out_phase_d;
  logic            out_wrap_q, out_wrap_d;
  logic            overrun_q, overrun_d;

  logic [PW-1:0]   acc_sum, sync_val, freq_clamped, next_phase, rep_phase;
  logic            acc_wrap, sync_hit, next_wrap;

  phase_mod_add #(.PW(PW), .MOD(MOD)) u_acc (
    .a    (phase_q[ch_q]),
    .b    ($signed({1'b0, freq_q[ch_q]})),
    .sum  (acc_sum),
    .wrap (acc_wrap)
  );

  // sync_phase < 2*MOD always holds, so a single conditional subtract reduces it
  assign sync_val     = ({1'b0, sync_phase} >= MOD) ? sync_phase - MOD[PW-1:0] : sync_phase;
  assign freq_clamped = ({1'b0, freq_data} >= MOD) ? FREQ_MAX : freq_data;

  // A sync landing on the channel being processed overrides the accumulation
  assign sync_hit   = (state_q == ST_RUN) && sync_req && (sync_ch == ch_q);
  assign next_phase = sync_hit ? sync_val : acc_sum;
  assign next_wrap  = acc_wrap && !sync_hit;

`ifdef MULTI_PHASE_INTEGRATOR_PM_EN
  logic pm_wrap;
  phase_mod_add #(.PW(PW), .MOD(MOD)) u_pm (
    .a    (next_phase),
    .b    ({pm_in[PW-1], pm_in}),
    .sum  (rep_phase),
    .wrap (pm_wrap)
  );
  assign proc_ch = ch_q;
`else
  assign rep_phase = next_phase;
`endif

  always_comb begin
    state_d     = state_q;
    ch_d        = ch_q;
    phase_d     = phase_q;
    freq_d      = freq_q;
    out_valid_d = 1'b0;
    out_ch_d    = out_ch_q;
    out_phase_d = out_phase_q;
    out_wrap_d  = out_wrap_q;
    overrun_d   = 1'b0;

    case (state_q)
      ST_IDLE: begin
        if (tick) begin
          state_d = ST_RUN;
          ch_d    = '0;
        end
      end
      ST_RUN: begin
        phase_d[ch_q] = next_phase;
        out_valid_d   = 1'b1;
        out_ch_d      = ch_q;
        out_phase_d   = rep_phase[PW-1:FRAC_BITS];
        out_wrap_d    = next_wrap;
        overrun_d     = tick;
        if (ch_q == LAST_CH) begin
          state_d = ST_IDLE;
          ch_d    = '0;
        end else begin
          ch_d = ch_q + 1'b1;
        end
      end
      default: state_d = ST_IDLE;
    endcase

    // Applied after the update so sync always wins on a collision; freq writes
    // land after the read, so the channel in flight sees the new value next sweep.
    if (sync_req) phase_d[sync_ch] = sync_val;
    if (freq_we)  freq_d[freq_ch]  = freq_clamped;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= ST_IDLE;
      ch_q        <= '0;
      phase_q     <= '{default: '0};
      freq_q      <= '{default: '0};
      out_valid_q <= 1'b0;
      out_ch_q    <= '0;
      out_phase_q <= '0;
      out_wrap_q  <= 1'b0;
      overrun_q   <= 1'b0;
    end else begin
      state_q     <= state_d;
      ch_q        <= ch_d;
      phase_q     <= phase_d;
      freq_q      <= freq_d;
      out_valid_q <= out_valid_d;
      out_ch_q    <= out_ch_d;
      out_phase_q <= out_phase_d;
      out_wrap_q  <= out_wrap_d;
      overrun_q   <= overrun_d;
    end
  end

  assign busy      = (state_q == ST_RUN);
  assign overrun   = overrun_q;
  assign out_valid = out_valid_q;
  assign out_ch    = out_ch_q;
  assign out_phase = out_phase_q;
  assign out_wrap  = out_wrap_q;
endmodule

// File: tb/tb_multi_phase_integrator.sv
module tb_multi_phase_integrator;
  localparam int     CH  = 8;
  localparam int     IB  = 16;
  localparam int     PW  = 24;
  localparam longint MOD = 64'd48000 * 64'd256;

  logic          clk = 1'b0;
  logic          rst = 1'b0, tick = 1'b0, freq_we = 1'b0, sync_req = 1'b0;
  logic [2:0]    freq_ch = '0, sync_ch = '0;
  logic [PW-1:0] freq_data = '0, sync_phase = '0;
  logic          busy, overrun, out_valid, out_wrap;
  logic [2:0]    out_ch;
  logic [IB-1:0] out_phase;
`ifdef MULTI_PHASE_INTEGRATOR_PM_EN
  logic signed [PW-1:0] pm_in = '0;
  logic [2:0]           proc_ch;
`endif

  always #5 clk = ~clk;

  multi_phase_integrator dut (
    .clk(clk), .rst(rst), .tick(tick),
    .freq_we(freq_we), .freq_ch(freq_ch), .freq_data(freq_data),
    .sync_req(sync_req), .sync_ch(sync_ch), .sync_phase(sync_phase),
`ifdef MULTI_PHASE_INTEGRATOR_PM_EN
    .pm_in(pm_in), .proc_ch(proc_ch),
`endif
    .busy(busy), .overrun(overrun), .out_valid(out_valid),
    .out_ch(out_ch), .out_phase(out_phase), .out_wrap(out_wrap)
  );

  // Reference model: per-channel fine phase and frequency, plus sweep position.
  longint mph [CH];
  longint mfr [CH];
  bit     m_run;
  int     m_pos;
  bit     e_valid, e_wrap, e_ov, e_busy;
  longint e_ch, e_phase;

  int     n_chk, n_pass, valid_cnt;
  longint last_ph [CH];
  bit     last_wr [CH];

  task automatic chk(input string name, input longint act, input longint exp);
    n_chk++;
    if (act == exp) n_pass++;
    else $display("FAIL %s: got %0d expected %0d (t=%0t)", name, act, exp, $time);
  endtask

  // Advance the model by one clock using the inputs currently applied.
  task automatic model_step();
    longint sv, s, n, r, f;
    bit     w;
    int     p;
    if (rst) begin
      foreach (mph[i]) begin mph[i] = 0; mfr[i] = 0; end
      m_run = 0; m_pos = 0;
      e_valid = 0; e_wrap = 0; e_ov = 0; e_busy = 0; e_ch = 0; e_phase = 0;
      return;
    end
    e_valid = 0; e_ov = 0;
    sv = longint'(sync_phase);
    if (sv >= MOD) sv -= MOD;
    if (m_run) begin
      p = m_pos;
      s = mph[p] + mfr[p];
      w = (s >= MOD);
      n = w ? s - MOD : s;
      if (sync_req && int'(sync_ch) == p) begin n = sv; w = 0; end
      mph[p] = n;
      r = n;
`ifdef MULTI_PHASE_INTEGRATOR_PM_EN
      r = n + longint'(pm_in);
      if (r < 0) r += MOD; else if (r >= MOD) r -= MOD;
`endif
      e_valid = 1; e_ch = p; e_phase = r / 256; e_wrap = w;
      e_ov = tick;
      m_pos++;
      if (m_pos == CH) begin m_run = 0; m_pos = 0; end
    end else if (tick) begin
      m_run = 1; m_pos = 0;
    end
    if (sync_req) mph[sync_ch] = sv;
    if (freq_we) begin
      f = longint'(freq_data);
      if (f >= MOD) f = MOD - 1;
      mfr[freq_ch] = f;
    end
    e_busy = m_run;
  endtask

  // One clock: model, edge, compare every output, then release strobes.
  task automatic step();
    model_step();
    @(posedge clk); #1;
    chk("busy", busy, e_busy);
    chk("overrun", overrun, e_ov);
    chk("out_valid", out_valid, e_valid);
    chk("out_ch", out_ch, e_ch);
    chk("out_phase", out_phase, e_phase);
    chk("out_wrap", out_wrap, e_wrap);
    if (out_valid) begin
      valid_cnt++;
      last_ph[out_ch] = out_phase;
      last_wr[out_ch] = out_wrap;
    end
    rst = 0; tick = 0; freq_we = 0; sync_req = 0;
`ifdef MULTI_PHASE_INTEGRATOR_PM_EN
    pm_in = '0;
`endif
  endtask

  task automatic sweep();
    tick = 1;
    step();
    repeat (CH + 1) step();
  endtask

  task automatic wr_freq(input int ch, input logic [PW-1:0] d);
    freq_we = 1; freq_ch = 3'(ch); freq_data = d;
    step();
  endtask

  task automatic do_sync(input int ch, input logic [PW-1:0] d);
    sync_req = 1; sync_ch = 3'(ch); sync_phase = d;
    step();
  endtask

  initial begin
    n_chk = 0; n_pass = 0;
    foreach (mph[i]) begin mph[i] = 0; mfr[i] = 0; end
    m_run = 0; m_pos = 0;

    // 1: reset, then ch0 at 1.0 per tick
    rst = 1; step(); rst = 1; step();
    chk("rst_out_phase", out_phase, 0);
    chk("rst_busy", busy, 0);
    wr_freq(0, 24'h000100);
    for (int k = 1; k <= 3; k++) begin
      valid_cnt = 0;
      sweep();
      chk("t1_ch0_phase", last_ph[0], k);
      chk("t1_ch7_phase", last_ph[7], 0);
      chk("t1_valid_cnt", valid_cnt, CH);
    end

    // 2: wrap boundary
    do_sync(0, 24'(47999 * 256));
    sweep();
    chk("t2_wrap_phase", last_ph[0], 0);
    chk("t2_wrap_flag", last_wr[0], 1);
    sweep();
    chk("t2_after_phase", last_ph[0], 1);
    chk("t2_after_flag", last_wr[0], 0);

    // 3: frequency clamp
    wr_freq(1, 24'hFFFFFF);
    do_sync(1, 24'h0);
    sweep();
    chk("t3_clamp_phase", last_ph[1], 47999);
    chk("t3_clamp_wrap", last_wr[1], 0);

    // 4: tick while busy
    valid_cnt = 0;
    tick = 1; step();
    step();
    tick = 1; step();
    chk("t4_overrun_hi", overrun, 1);
    step();
    chk("t4_overrun_lo", overrun, 0);
    repeat (6) step();
    chk("t4_valid_cnt", valid_cnt, CH);
    chk("t4_idle", busy, 0);

    // 5: sync collides with processing of ch3
    wr_freq(3, 24'h000500);
    tick = 1; step();
    repeat (3) step();
    do_sync(3, 24'h123456);
    repeat (CH - 3) step();
    chk("t5_sync_phase", last_ph[3], 16'h1234);
    chk("t5_sync_wrap", last_wr[3], 0);

    // 6: reset during ch4
    tick = 1; step();
    repeat (4) step();
    valid_cnt = 0;
    rst = 1; step();
    repeat (5) step();
    chk("t6_no_valid", valid_cnt, 0);
    chk("t6_out_phase", out_phase, 0);
    chk("t6_out_ch", out_ch, 0);
    wr_freq(0, 24'h000300);
    sweep();
    chk("t6_ch0_phase", last_ph[0], 3);

`ifdef MULTI_PHASE_INTEGRATOR_PM_EN
    // PM: phase 100 with -200 modulation reports 47900
    wr_freq(0, 24'h0);
    do_sync(0, 24'(100 * 256));
    tick = 1; step();
    pm_in = -24'sd51200; step();
    repeat (CH) step();
    chk("pm_phase", last_ph[0], 47900);
`endif

    // Randomized traffic against the model
    for (int c = 0; c < 3000; c++) begin
      tick     = ($urandom_range(0, 9) == 0);
      freq_we  = ($urandom_range(0, 3) == 0);
      freq_ch  = 3'($urandom_range(0, CH - 1));
      freq_data = ($urandom_range(0, 1) == 0) ? PW'($urandom_range(0, 24'h20000)) : PW'($urandom);
      sync_req = ($urandom_range(0, 7) == 0);
      sync_ch  = 3'($urandom_range(0, CH - 1));
      sync_phase = PW'($urandom);
      rst      = ($urandom_range(0, 399) == 0);
`ifdef MULTI_PHASE_INTEGRATOR_PM_EN
      pm_in    = PW'($urandom);
`endif
      step();
    end

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end
endmodule
